// File: rtl/calc_seq_if.sv
// Control bundle between the calc_seq sequencer and its datapath/requester.
// The sequencer sits on the slave side. The environment (requester plus
// datapath) sits on the master side.
interface calc_seq_if #(
   parameter int OPW = 3
);
   // requests and status from the environment
   logic           Go;
   logic [OPW-1:0] f;
   logic           Done_Calc;
   logic           Done_Div;
   logic           div_zero;
   logic           abort;
   // strobes and status from the sequencer
   logic           ld_in;
   logic           alu_start;
   logic           div_start;
   logic           mul_en;
   logic           res_ld;
   logic [1:0]     alu_op;
   logic [2:0]     res_sel;
   logic           Done;
   logic           Busy;
   logic [1:0]     Err;

   modport slave (
      input  Go, f, Done_Calc, Done_Div, div_zero, abort,
      output ld_in, alu_start, div_start, mul_en, res_ld, alu_op, res_sel,
             Done, Busy, Err
   );

   modport master (
      output Go, f, Done_Calc, Done_Div, div_zero, abort,
      input  ld_in, alu_start, div_start, mul_en, res_ld, alu_op, res_sel,
             Done, Busy, Err
   );
endinterface

// File: rtl/calc_seq.sv
// calc_seq: operation sequencer for a small ALU/divider/multiplier datapath.
// Every output is a register. Each output is loaded with the value decoded
// from the state being entered, so the outputs in any cycle reflect only the
// current state and the latched opcode.
module calc_seq #(
   parameter int OPW     = 3,
   parameter int TMO_W   = 8,
   parameter int MUL_CYC = 2
) (
   input  logic       clk,
   input  logic       rst,
   calc_seq_if.slave  bus
);
   localparam int TMO = (1 << TMO_W) - 1;
   localparam int MCW = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_DECODE, S_ALU_WAIT, S_DIV_WAIT, S_MUL, S_WRITE, S_DONE
   } state_t;

   state_t           r_state, w_state_next;
   logic [OPW-1:0]   r_qf, w_qf_next;
   logic [TMO_W-1:0] r_wcnt, w_wcnt_next;
   logic [MCW-1:0]   r_mcnt, w_mcnt_next;
   logic [1:0]       r_err, w_err_next;

   logic       r_ld_in, r_alu_start, r_div_start, r_mul_en, r_res_ld, r_done, r_busy;
   logic       w_ld_in, w_alu_start, w_div_start, w_mul_en, w_res_ld, w_done, w_busy;
   logic [1:0] r_alu_op, w_alu_op;
   logic [2:0] r_res_sel, w_res_sel;

   logic w_illegal;      // latched opcode is 8 or above
   logic w_illegal_next; // opcode that will be latched after this edge is 8 or above
   logic w_wait_tmo;     // the current wait cycle is the last one allowed
   logic w_nq_alu;       // next latched opcode is an ALU function (0-3)

   // Opcodes above 7 exist only when the opcode field is wider than 3 bits.
   generate
      if (OPW > 3) begin : g_wide_op
         assign w_illegal      = |r_qf[OPW-1:3];
         assign w_illegal_next = |w_qf_next[OPW-1:3];
      end else begin : g_narrow_op
         assign w_illegal      = 1'b0;
         assign w_illegal_next = 1'b0;
      end
   endgenerate

   // The wait counter holds the number of completed wait cycles. The
   // TMO-th wait cycle is therefore the cycle in which it reads TMO-1.
   assign w_wait_tmo = (r_wcnt == TMO_W'(TMO - 1));
   assign w_nq_alu   = !w_illegal_next && !w_qf_next[2];

   // Next-state, opcode latch, counters and error code.
   always_comb begin
      w_state_next = r_state;
      w_qf_next    = r_qf;
      w_wcnt_next  = r_wcnt;
      w_mcnt_next  = r_mcnt;
      w_err_next   = r_err;
      if (r_state != S_IDLE && bus.abort) begin
         w_state_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.Go) begin
                  w_qf_next    = bus.f;
                  w_err_next   = 2'b00;  // Err reads 00 from LOAD onward
                  w_state_next = S_LOAD;
               end
            end
            S_LOAD: w_state_next = S_DECODE;
            S_DECODE: begin
               w_wcnt_next = '0;
               w_mcnt_next = '0;
               if (w_illegal) begin
                  w_err_next   = 2'b11;
                  w_state_next = S_DONE;
               end else begin
                  case (r_qf[2:0])
                     3'd0, 3'd1, 3'd2, 3'd3: w_state_next = S_ALU_WAIT;
                     3'd4: begin
                        if (bus.div_zero) begin
                           w_err_next   = 2'b01;
                           w_state_next = S_DONE;
                        end else begin
                           w_state_next = S_DIV_WAIT;
                        end
                     end
                     3'd5:    w_state_next = S_MUL;
                     default: w_state_next = S_WRITE;
                  endcase
               end
            end
            S_ALU_WAIT, S_DIV_WAIT: begin
               // a completion in the final allowed cycle still wins over the timeout
               if ((r_state == S_ALU_WAIT) ? bus.Done_Calc : bus.Done_Div) begin
                  w_state_next = S_WRITE;
               end else if (w_wait_tmo) begin
                  w_err_next   = 2'b10;
                  w_state_next = S_DONE;
               end else begin
                  w_wcnt_next = r_wcnt + 1'b1;
               end
            end
            S_MUL: begin
               if (r_mcnt == MCW'(MUL_CYC - 1)) w_state_next = S_WRITE;
               else                             w_mcnt_next  = r_mcnt + 1'b1;
            end
            S_WRITE: w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   // Output values for the state being entered.
   always_comb begin
      w_ld_in     = (w_state_next == S_LOAD);
      w_alu_start = (w_state_next == S_DECODE) && w_nq_alu;
      // div_zero is only known when DECODE is left, so the divider start
      // strobe occupies the first DIV_WAIT cycle instead of DECODE.
      w_div_start = (r_state == S_DECODE) && (w_state_next == S_DIV_WAIT);
      w_mul_en    = (w_state_next == S_MUL);
      w_res_ld    = (w_state_next == S_WRITE);
      w_done      = (w_state_next == S_DONE);
      w_busy      = (w_state_next != S_IDLE);
      w_alu_op    = 2'b00;
      if (w_nq_alu && (w_state_next == S_DECODE || w_state_next == S_ALU_WAIT ||
                       w_state_next == S_WRITE))
         w_alu_op = w_qf_next[1:0];
      w_res_sel = 3'd0;
      if (w_state_next == S_WRITE) begin
         case (w_qf_next[2:0])
            3'd4:    w_res_sel = 3'd1;
            3'd5:    w_res_sel = 3'd2;
            3'd6:    w_res_sel = 3'd3;
            3'd7:    w_res_sel = 3'd4;
            default: w_res_sel = 3'd0;
         endcase
      end
   end

   // State and all registered outputs. Reset clears everything at once,
   // abandoning any operation in flight without a Done.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_qf        <= '0;
         r_wcnt      <= '0;
         r_mcnt      <= '0;
         r_err       <= 2'b00;
         r_ld_in     <= 1'b0;
         r_alu_start <= 1'b0;
         r_div_start <= 1'b0;
         r_mul_en    <= 1'b0;
         r_res_ld    <= 1'b0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
         r_alu_op    <= 2'b00;
         r_res_sel   <= 3'd0;
      end else begin
         r_state     <= w_state_next;
         r_qf        <= w_qf_next;
         r_wcnt      <= w_wcnt_next;
         r_mcnt      <= w_mcnt_next;
         r_err       <= w_err_next;
         r_ld_in     <= w_ld_in;
         r_alu_start <= w_alu_start;
         r_div_start <= w_div_start;
         r_mul_en    <= w_mul_en;
         r_res_ld    <= w_res_ld;
         r_done      <= w_done;
         r_busy      <= w_busy;
         r_alu_op    <= w_alu_op;
         r_res_sel   <= w_res_sel;
      end
   end

   assign bus.ld_in     = r_ld_in;
   assign bus.alu_start = r_alu_start;
   assign bus.div_start = r_div_start;
   assign bus.mul_en    = r_mul_en;
   assign bus.res_ld    = r_res_ld;
   assign bus.alu_op    = r_alu_op;
   assign bus.res_sel   = r_res_sel;
   assign bus.Done      = r_done;
   assign bus.Busy      = r_busy;
   assign bus.Err       = r_err;
endmodule

// File: tb/tb_calc_seq.sv
// Bench for calc_seq: directed scenarios followed by randomized operations,
// each checked against a cycle-level expectation derived from the opcode rules.
module tb_calc_seq;
   localparam int OPW     = 4;
   localparam int TMO_W   = 4;
   localparam int MUL_CYC = 3;
   localparam int TMO     = (1 << TMO_W) - 1;

   logic clk = 1'b0;
   logic rst;
   int   n_vec    = 0;
   int   n_err    = 0;
   int   prev_err = 0;
   int   txn_id   = 0;

   always #5 clk = ~clk;

   calc_seq_if #(.OPW(OPW)) bus ();

   calc_seq #(.OPW(OPW), .TMO_W(TMO_W), .MUL_CYC(MUL_CYC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   function automatic int all_outs();
      return int'({bus.ld_in, bus.alu_start, bus.div_start, bus.mul_en, bus.res_ld,
                   bus.alu_op, bus.res_sel, bus.Done, bus.Busy, bus.Err});
   endfunction

   // One operation. Cycle c is the period following rising edge c-1, and Go
   // is sampled at edge 0. k is the wait cycle in which the completion input
   // rises (0 means it never does). ab_sel selects an abort cycle (0 means no abort).
   task automatic run_txn(input int op, input bit dz, input int k, input int ab_sel);
      int  exp_done, exp_err, exp_wr, exp_sel, exp_alu, exp_div, exp_mul, exp_busy;
      int  lim, ab, end_c;
      bit  divp;
      int  o_done_cyc, o_done_n, o_ld, o_alu, o_div, o_mul, o_wr, o_sel;
      int  o_aop_s, o_aop_w, o_busy, o_err1, o_errf;
      // expectations from the opcode rules
      exp_alu = 0; exp_div = 0; exp_mul = 0; exp_wr = 0; exp_err = 0;
      divp = (op == 4) && !dz;
      if (op < 4 || divp) begin
         if (op < 4) exp_alu = 1; else exp_div = 1;
         if (k >= 1 && k <= TMO) begin exp_wr = 3 + k; exp_done = 4 + k; end
         else begin exp_done = 3 + TMO; exp_err = 2; end
      end else if (op == 4) begin
         exp_done = 3; exp_err = 1;
      end else if (op == 5) begin
         exp_mul = MUL_CYC; exp_wr = 3 + MUL_CYC; exp_done = 4 + MUL_CYC;
      end else if (op < 8) begin
         exp_wr = 3; exp_done = 4;
      end else begin
         exp_done = 3; exp_err = 3;
      end
      exp_sel = (op < 4) ? 0 : (op == 4) ? 1 : (op == 5) ? 2 : (op == 6) ? 3 : 4;
      ab = 0;
      if (ab_sel > 0) begin
         lim = (exp_wr != 0) ? exp_wr : exp_done;
         ab  = 1 + (ab_sel - 1) % (lim - 1);
      end
      if (ab > 0) begin
         end_c    = ab;
         exp_alu  = (exp_alu != 0 && ab >= 2) ? 1 : 0;
         exp_div  = (exp_div != 0 && ab >= 3) ? 1 : 0;
         exp_mul  = (exp_mul != 0) ? ((ab - 2 < 0) ? 0 : (ab - 2 > MUL_CYC) ? MUL_CYC : ab - 2) : 0;
         exp_wr   = 0;
         exp_done = 0;
         exp_err  = 0;
      end else begin
         end_c = exp_done;
      end
      exp_busy = end_c;

      chk("err_hold_idle", int'(bus.Err), prev_err);
      bus.f = OPW'(op); bus.Go = 1'b1; bus.div_zero = dz; bus.abort = 1'b0;
      bus.Done_Calc = 1'b0; bus.Done_Div = 1'b0;
      o_done_cyc = 0; o_done_n = 0; o_ld = 0; o_alu = 0; o_div = 0; o_mul = 0;
      o_wr = 0; o_sel = -1; o_aop_s = -1; o_aop_w = -1; o_busy = 0; o_err1 = -1; o_errf = -1;
      for (int c = 1; c <= end_c + 2; c++) begin
         @(negedge clk);
         if (bus.Done) begin o_done_n++; if (o_done_cyc == 0) o_done_cyc = c; end
         if (bus.ld_in) o_ld++;
         if (bus.alu_start) begin o_alu++; o_aop_s = int'(bus.alu_op); end
         if (bus.div_start) o_div++;
         if (bus.mul_en) o_mul++;
         if (bus.res_ld) begin o_wr++; o_sel = int'(bus.res_sel); o_aop_w = int'(bus.alu_op); end
         if (bus.Busy) o_busy++;
         if (c == 1) o_err1 = int'(bus.Err);
         if (c == end_c + 2) o_errf = int'(bus.Err);
         // inputs for this cycle, sampled at the next rising edge
         bus.Go        = (c < end_c) ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.f         = OPW'($urandom);
         bus.abort     = (c == ab);
         bus.Done_Calc = (op < 4) && (k >= 1) && (c == 2 + k);
         bus.Done_Div  = divp && (k >= 1) && (c == 2 + k);
      end
      bus.Go = 1'b0; bus.abort = 1'b0; bus.Done_Calc = 1'b0; bus.Done_Div = 1'b0;

      chk("done_cycle", o_done_cyc, exp_done);
      chk("done_pulses", o_done_n, (exp_done != 0) ? 1 : 0);
      chk("ld_in_count", o_ld, 1);
      chk("alu_start_count", o_alu, exp_alu);
      chk("div_start_count", o_div, exp_div);
      chk("mul_en_cycles", o_mul, exp_mul);
      chk("res_ld_count", o_wr, (exp_wr != 0) ? 1 : 0);
      chk("res_sel", o_sel, (exp_wr != 0) ? exp_sel : -1);
      chk("alu_op_decode", o_aop_s, (exp_alu != 0) ? (op % 4) : -1);
      chk("alu_op_write", o_aop_w, (exp_wr != 0) ? ((op < 4) ? op : 0) : -1);
      chk("busy_cycles", o_busy, exp_busy);
      chk("err_in_load", o_err1, 0);
      chk("err_final", o_errf, exp_err);
      prev_err = exp_err;
      txn_id++;
      $display("txn %0d op=%0d dz=%0d k=%0d abort@%0d done@%0d(exp %0d) err=%0d(exp %0d)",
               txn_id, op, dz, k, ab, o_done_cyc, exp_done, o_errf, exp_err);
   endtask

   initial begin
      int op, k, r, ab_sel;
      bit dz;
      rst = 1'b0;
      bus.Go = 1'b0; bus.f = '0; bus.Done_Calc = 1'b0; bus.Done_Div = 1'b0;
      bus.div_zero = 1'b0; bus.abort = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", all_outs(), 0);
      rst = 1'b1;

      // directed scenarios
      run_txn(6, 0, 0, 0);    // pass-through A: write at 3, done at 4
      run_txn(2, 0, 3, 0);    // ALU, completion in third wait cycle: done at 7
      run_txn(4, 1, 0, 0);    // divide by zero: done at 3, Err=01
      run_txn(4, 0, 0, 0);    // divider never completes: timeout, Err=10
      run_txn(4, 0, 15, 0);   // completion in the final wait cycle beats timeout
      run_txn(5, 0, 0, 0);    // multiply: 3 mul_en cycles, done at 7
      run_txn(5, 0, 0, 4);    // abort in the second MUL cycle
      run_txn(9, 0, 0, 0);    // illegal opcode: Err=11
      run_txn(7, 0, 0, 0);    // pass-through B
      run_txn(0, 0, 1, 0);    // shortest ALU wait

      // reset during DIV_WAIT, then a run starting on the first edge after release
      bus.f = OPW'(4); bus.div_zero = 1'b0; bus.Go = 1'b1;
      @(negedge clk);
      bus.Go = 1'b0;
      repeat (4) @(negedge clk);
      chk("busy_before_reset", int'(bus.Busy), 1);
      #2 rst = 1'b0;
      #1 chk("async_reset_outputs", all_outs(), 0);
      @(negedge clk);
      rst = 1'b1;
      prev_err = 0;
      run_txn(6, 0, 0, 0);

      // randomized operations
      for (int t = 0; t < 60; t++) begin
         op     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
         dz     = 1'($urandom_range(0, 1));
         r      = $urandom_range(0, 9);
         k      = (r == 0) ? 0 : (r == 1) ? TMO : int'($urandom_range(1, 6));
         ab_sel = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 20)) : 0;
         run_txn(op, dz, k, ab_sel);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
